// File: rtl/load_store_unit.sv
// Load/store unit: maps byte-addressed RV32I loads/stores onto a word-wide data memory,
// using read-modify-write for sub-word stores since the memory has only a full-word write enable.
module load_store_unit #(
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DATA_MEM_SIZE  = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_Req,
    input  logic                      i_We,
    input  logic [2:0]                i_Funct3,
    input  logic [31:0]               i_Addr,
    input  logic [DATA_WIDTH-1:0]     i_WData,
    output logic                      o_Ready,
    output logic                      o_Done,
    output logic                      o_Err,
    output logic [DATA_WIDTH-1:0]     o_RData,
    output logic [MEM_ADDR_WIDTH-1:0] o_MemAddr,
    output logic [DATA_WIDTH-1:0]     o_MemData,
    output logic                      o_MemWrEn,
    input  logic [DATA_WIDTH-1:0]     i_MemData
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD, S_WR, S_RMW_RD, S_RMW_WR, S_DONE, S_ERR
    } state_t;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH+1:0] addr_q;
    logic [2:0]                funct3_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [DATA_WIDTH-1:0]     merge_q;

    logic                      f3_ok, align_ok, range_ok;
    logic [31:0]               widx;
    logic [7:0]                lane_b;
    logic [15:0]               lane_h;
    logic [DATA_WIDTH-1:0]     load_val, merge_val;

    // Request legality is judged on the live inputs in the capture cycle.
    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b1;
        widx     = {2'b00, i_Addr[31:2]};
        range_ok = (widx < DATA_MEM_SIZE);
        if (i_We) f3_ok = i_Funct3 inside {3'b000, 3'b001, 3'b010};
        else      f3_ok = i_Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        case (i_Funct3[1:0])
            2'b01:   align_ok = ~i_Addr[0];
            2'b10:   align_ok = (i_Addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_Req) begin
                    if (!(f3_ok && align_ok && range_ok)) state_d = S_ERR;
                    else if (!i_We)                       state_d = S_LD;
                    else if (i_Funct3 == 3'b010)          state_d = S_WR;
                    else                                  state_d = S_RMW_RD;
                end
            end
            S_LD:     state_d = S_DONE;
            S_WR:     state_d = S_DONE;
            S_RMW_RD: state_d = S_RMW_WR;
            S_RMW_WR: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lane_b    = i_MemData[{addr_q[1:0], 3'b000} +: 8];
        lane_h    = addr_q[1] ? i_MemData[31:16] : i_MemData[15:0];
        merge_val = i_MemData;
        case (funct3_q)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_val = {24'd0, lane_b};
            3'b101:  load_val = {16'd0, lane_h};
            default: load_val = i_MemData;
        endcase
        if (funct3_q[0]) merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else             merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            merge_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && i_Req) begin
                addr_q   <= i_Addr[MEM_ADDR_WIDTH+1:0];
                funct3_q <= i_Funct3;
                wdata_q  <= i_WData;
            end
            if (state_q == S_LD)     rdata_q <= load_val;
            if (state_q == S_RMW_RD) merge_q <= merge_val;
        end
    end

    // Strobes decode straight from the state register so reset cancels a pending write immediately.
    assign o_Ready   = (state_q == S_IDLE);
    assign o_Done    = (state_q == S_DONE) || (state_q == S_ERR);
    assign o_Err     = (state_q == S_ERR);
    assign o_MemWrEn = (state_q == S_WR) || (state_q == S_RMW_WR);
    assign o_MemData = (state_q == S_WR)     ? wdata_q :
                       (state_q == S_RMW_WR) ? merge_q : '0;
    assign o_MemAddr = addr_q[MEM_ADDR_WIDTH+1:2];
    assign o_RData   = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

    localparam int unsigned AW = 4;
    localparam int unsigned NW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_Req, i_We;
    logic [2:0]    i_Funct3;
    logic [31:0]   i_Addr, i_WData;
    logic          o_Ready, o_Done, o_Err, o_MemWrEn;
    logic [31:0]   o_RData, o_MemData, i_MemData;
    logic [AW-1:0] o_MemAddr;

    logic [31:0]   mem [NW];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_idx = '0;
    logic [31:0]   bd_data = '0;
    int            wr_cnt = 0;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(32), .DATA_MEM_SIZE(NW)) dut (
        .clk(clk), .reset(reset), .i_Req(i_Req), .i_We(i_We), .i_Funct3(i_Funct3),
        .i_Addr(i_Addr), .i_WData(i_WData), .o_Ready(o_Ready), .o_Done(o_Done),
        .o_Err(o_Err), .o_RData(o_RData), .o_MemAddr(o_MemAddr), .o_MemData(o_MemData),
        .o_MemWrEn(o_MemWrEn), .i_MemData(i_MemData)
    );

    always #5 clk = ~clk;

    assign i_MemData = mem[o_MemAddr];

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (o_MemWrEn) begin
            mem[o_MemAddr] <= o_MemData;
            wr_cnt <= wr_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = AW'(idx); bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic wait_ready();
        @(negedge clk);
        for (int n = 0; n < 8 && !o_Ready; n++) @(negedge clk);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic err);
        wait_ready();
        i_Req = 1'b1; i_We = we; i_Funct3 = f3; i_Addr = addr; i_WData = wd;
        @(posedge clk); #1;
        i_Req = 1'b0;
        lat = 0; err = 1'bx;
        for (int n = 1; n <= 8; n++) begin
            if (o_Done) begin
                lat = n; err = o_Err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        logic        err;
        logic [31:0] rd;
        int          wr;
    } vec_t;

    vec_t v [20];

    initial begin
        int lat, w0;
        logic err;

        v[0]  = '{1'b0, 3'b000, 32'h04, 32'h0,         2, 1'b0, 32'hFFFF_FFF3, 0};
        v[1]  = '{1'b0, 3'b101, 32'h06, 32'h0,         2, 1'b0, 32'h0000_8081, 0};
        v[2]  = '{1'b0, 3'b001, 32'h06, 32'h0,         2, 1'b0, 32'hFFFF_8081, 0};
        v[3]  = '{1'b0, 3'b100, 32'h05, 32'h0,         2, 1'b0, 32'h0000_0082, 0};
        v[4]  = '{1'b0, 3'b010, 32'h04, 32'h0,         2, 1'b0, 32'h8081_82F3, 0};
        v[5]  = '{1'b1, 3'b000, 32'h0A, 32'h0000_00AB, 3, 1'b0, 32'h8081_82F3, 1};
        v[6]  = '{1'b0, 3'b010, 32'h08, 32'h0,         2, 1'b0, 32'h11AB_3344, 0};
        v[7]  = '{1'b0, 3'b010, 32'h05, 32'h0,         1, 1'b1, 32'h11AB_3344, 0};
        v[8]  = '{1'b1, 3'b001, 32'h03, 32'h0000_1234, 1, 1'b1, 32'h11AB_3344, 0};
        v[9]  = '{1'b0, 3'b011, 32'h04, 32'h0,         1, 1'b1, 32'h11AB_3344, 0};
        v[10] = '{1'b0, 3'b010, 32'h40, 32'h0,         1, 1'b1, 32'h11AB_3344, 0};
        v[11] = '{1'b1, 3'b010, 32'h0C, 32'h0102_0304, 2, 1'b0, 32'h11AB_3344, 1};
        v[12] = '{1'b1, 3'b001, 32'h0E, 32'hFFFF_BEEF, 3, 1'b0, 32'h11AB_3344, 1};
        v[13] = '{1'b0, 3'b000, 32'h0F, 32'h0,         2, 1'b0, 32'hFFFF_FFBE, 0};
        v[14] = '{1'b1, 3'b100, 32'h00, 32'h0000_0077, 1, 1'b1, 32'hFFFF_FFBE, 0};
        v[15] = '{1'b0, 3'b001, 32'h04, 32'h0,         2, 1'b0, 32'hFFFF_82F3, 0};
        v[16] = '{1'b1, 3'b000, 32'h3F, 32'h0000_0055, 3, 1'b0, 32'hFFFF_82F3, 1};
        v[17] = '{1'b0, 3'b010, 32'h3C, 32'h0,         2, 1'b0, 32'h5500_0000, 0};
        v[18] = '{1'b0, 3'b010, 32'h0C, 32'h0,         2, 1'b0, 32'hBEEF_0304, 0};
        v[19] = '{1'b0, 3'b101, 32'h0C, 32'h0,         2, 1'b0, 32'h0000_0304, 0};

        reset = 1'b1; i_Req = 1'b0; i_We = 1'b0; i_Funct3 = '0; i_Addr = '0; i_WData = '0;
        for (int i = 0; i < int'(NW); i++) preload(i, 32'h0);
        preload(1, 32'h8081_82F3);
        preload(2, 32'h1122_3344);

        chk("reset_ready",  {31'd0, o_Ready},   32'd1);
        chk("reset_done",   {31'd0, o_Done},    32'd0);
        chk("reset_err",    {31'd0, o_Err},     32'd0);
        chk("reset_wren",   {31'd0, o_MemWrEn}, 32'd0);
        chk("reset_rdata",  o_RData,            32'd0);
        chk("reset_memaddr",{28'd0, o_MemAddr}, 32'd0);
        chk("reset_memdata",o_MemData,          32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            w0 = wr_cnt;
            do_req(v[i].we, v[i].f3, v[i].addr, v[i].wd, lat, err);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, v[i].err});
            chk($sformatf("v%0d_rdata", i), o_RData, v[i].rd);
            chk($sformatf("v%0d_writes", i), 32'(wr_cnt - w0), 32'(v[i].wr));
        end
        chk("mem1_intact", mem[1],  32'h8081_82F3);
        chk("mem2_sb",     mem[2],  32'h11AB_3344);
        chk("mem3_sh",     mem[3],  32'hBEEF_0304);
        chk("mem15_sb",    mem[15], 32'h5500_0000);
        chk("mem0_intact", mem[0],  32'h0);

        // Reset while the RMW write is being presented.
        wait_ready();
        i_Req = 1'b1; i_We = 1'b1; i_Funct3 = 3'b001; i_Addr = 32'h8; i_WData = 32'h0000_BEEF;
        @(posedge clk); #1;
        i_Req = 1'b0;
        chk("rmw_rd_wren", {31'd0, o_MemWrEn}, 32'd0);
        @(posedge clk); #1;
        chk("rmw_wr_wren", {31'd0, o_MemWrEn}, 32'd1);
        chk("rmw_wr_addr", {28'd0, o_MemAddr}, 32'd2);
        w0 = wr_cnt;
        reset = 1'b1;
        #1;
        chk("rst_wren_drop", {31'd0, o_MemWrEn}, 32'd0);
        chk("rst_ready",     {31'd0, o_Ready},   32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("rst_mem2",     mem[2],  32'h11AB_3344);
        chk("rst_rdata",    o_RData, 32'd0);
        chk("rst_ready_after", {31'd0, o_Ready}, 32'd1);

        // Back-to-back requests with i_Req held high.
        w0 = wr_cnt;
        wait_ready();
        i_Req = 1'b1; i_We = 1'b1; i_Funct3 = 3'b010; i_Addr = 32'h0; i_WData = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        i_We = 1'b0; i_WData = 32'h0;
        chk("b2b_busy_t1", {31'd0, o_Ready}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_sw_done", {31'd0, o_Done}, 32'd1);
        chk("b2b_sw_err",  {31'd0, o_Err},  32'd0);
        @(posedge clk); #1;
        chk("b2b_idle_ready", {31'd0, o_Ready}, 32'd1);
        chk("b2b_idle_nodone", {31'd0, o_Done}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_lw_busy", {31'd0, o_Ready}, 32'd0);
        @(posedge clk); #1;
        i_Req = 1'b0;
        chk("b2b_lw_done",  {31'd0, o_Done}, 32'd1);
        chk("b2b_lw_rdata", o_RData, 32'hDEAD_BEEF);
        chk("b2b_writes",   32'(wr_cnt - w0), 32'd1);
        chk("b2b_mem0",     mem[0], 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
